mem_sequencer: RTL and testbench

MEM_SEQUENCER -- requirements
Module: mem_sequencer

---
 rtl/mem_sequencer_if.sv | 32 +++
 rtl/mem_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_mem_sequencer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_sequencer_if.sv
// mem_sequencer_if: command, matrix-RAM and ALU signals of the memory sequencer.
interface mem_sequencer_if;
    logic        start;
    logic [3:0]  opcode;
    logic [7:0]  adrs;
    logic [15:0] data;
    logic        busy;
    logic        done;
    logic        error;
    logic [7:0]  result;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata;
    logic        alu_start;
    logic [3:0]  alu_op;
    logic        alu_done;

    // Requester side: issues commands and also hosts the RAM and ALU.
    modport master (
        output start, opcode, adrs, data, mem_rdata, alu_done,
        input  busy, done, error, result, mem_addr, mem_wdata, mem_we,
               alu_start, alu_op
    );

    // Sequencer side.
    modport slave (
        input  start, opcode, adrs, data, mem_rdata, alu_done,
        output busy, done, error, result, mem_addr, mem_wdata, mem_we,
               alu_start, alu_op
    );
endinterface

// File: rtl/mem_sequencer.sv
// mem_sequencer: runs one decoded command at a time against the matrix RAM
// (single write, latency-aware read, 16-element clear) or launches the ALU
// and waits for it with a timeout.
module mem_sequencer #(
    parameter int READ_LATENCY = 2,
    parameter int ALU_TIMEOUT  = 255
) (
    input logic            clk,
    input logic            rst,
    mem_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ_WAIT,
        CLEAR,
        ALU_WAIT,
        DONE
    } state_t;

    localparam logic [3:0] OP_WRITE   = 4'h1;
    localparam logic [3:0] OP_READ    = 4'h2;
    localparam logic [3:0] OP_CLEAR   = 4'h3;
    localparam logic [7:0] READ_LAST  = 8'(READ_LATENCY);
    localparam logic [7:0] ALU_LAST   = 8'(ALU_TIMEOUT - 1);
    localparam logic [3:0] CLEAR_LAST = 4'hF;

    state_t     state;
    state_t     state_next;
    logic [7:0] cnt;
    logic [3:0] opcode_q;
    logic [7:0] adrs_q;
    logic [7:0] wdata_q;
    logic       error_q;
    logic       error_next;
    logic [7:0] result_q;
    logic       read_ready;
    logic       alu_expired;
    logic       unused_data_hi;

    // Opcodes 0 and 4..7 have no handler and go straight to DONE.
    function automatic state_t dispatch(input logic [3:0] op);
        state_t s;
        if (op == OP_WRITE)
            s = WRITE;
        else if (op == OP_READ)
            s = READ_WAIT;
        else if (op == OP_CLEAR)
            s = CLEAR;
        else if (op[3])
            s = ALU_WAIT;
        else
            s = DONE;
        return s;
    endfunction

    // Only the low byte of the immediate ever reaches the RAM.
    assign unused_data_hi = ^bus.data[15:8];

    // The counter restarts at zero on every state entry, so in READ_WAIT it
    // equals the cycles since the address went out and in ALU_WAIT the
    // cycles since alu_start.
    assign read_ready  = (state == READ_WAIT) && (cnt == READ_LAST);
    assign alu_expired = (state == ALU_WAIT) && (cnt == ALU_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state and completion-status decode; alu_done beats the timeout.
    always_comb begin
        state_next = state;
        error_next = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = dispatch(bus.opcode);
                    error_next = (dispatch(bus.opcode) == DONE);
                end
            end
            WRITE:     state_next = DONE;
            READ_WAIT: if (read_ready) state_next = DONE;
            CLEAR:     if (cnt[3:0] == CLEAR_LAST) state_next = DONE;
            ALU_WAIT: begin
                if (bus.alu_done) begin
                    state_next = DONE;
                end else if (alu_expired) begin
                    state_next = DONE;
                    error_next = 1'b1;
                end
            end
            DONE:      state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Shared cycle/element counter; CLEAR leaves at 15 so it never wraps.
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (state_next != state)
            cnt <= '0;
        else if (state == READ_WAIT || state == CLEAR || state == ALU_WAIT)
            cnt <= cnt + 8'd1;
    end

    // Command capture, only for a start accepted in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            opcode_q <= '0;
            adrs_q   <= '0;
            wdata_q  <= '0;
        end else if (state == IDLE && bus.start) begin
            opcode_q <= bus.opcode;
            adrs_q   <= bus.adrs;
            wdata_q  <= bus.data[7:0];
        end
    end

    // Status registers: error refreshes on each entry to DONE, result on
    // each completed read; both hold in between.
    always_ff @(posedge clk) begin
        if (rst) begin
            error_q  <= 1'b0;
            result_q <= '0;
        end else begin
            if (state != DONE && state_next == DONE)
                error_q <= error_next;
            if (read_ready)
                result_q <= bus.mem_rdata;
        end
    end

    // Moore outputs decoded from the state and captured command.
    always_comb begin
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_we    = 1'b0;
        bus.alu_start = 1'b0;
        bus.alu_op    = '0;
        case (state)
            WRITE: begin
                bus.busy      = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = adrs_q;
                bus.mem_wdata = wdata_q;
            end
            READ_WAIT: begin
                bus.busy     = 1'b1;
                bus.mem_addr = adrs_q;
            end
            CLEAR: begin
                bus.busy     = 1'b1;
                bus.mem_we   = 1'b1;
                bus.mem_addr = {2'b00, adrs_q[5:4], cnt[3:0]};
            end
            ALU_WAIT: begin
                bus.busy      = 1'b1;
                bus.alu_op    = opcode_q;
                bus.alu_start = (cnt == 8'd0);
            end
            DONE:    bus.done = 1'b1;
            default: ;
        endcase
    end

    assign bus.error  = error_q;
    assign bus.result = result_q;

    // Pulse-shape and write-enable sanity properties.
    property p_done_single;
        @(posedge clk) disable iff (rst) bus.done |=> !bus.done;
    endproperty
    property p_alu_start_single;
        @(posedge clk) disable iff (rst) bus.alu_start |=> !bus.alu_start;
    endproperty
    property p_we_only_busy;
        @(posedge clk) disable iff (rst) bus.mem_we |-> bus.busy;
    endproperty

    a_done_single:      assert property (p_done_single);
    a_alu_start_single: assert property (p_alu_start_single);
    a_we_only_busy:     assert property (p_we_only_busy);

endmodule

// File: tb/tb_mem_sequencer.sv
// tb_mem_sequencer: directed and randomized commands checked against a
// behavioural model of the sequencer, with a delayed-read RAM and an ALU stub.
module tb_mem_sequencer;

    localparam int READ_LAT = 2;
    localparam int ALU_TO   = 12;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mem_sequencer_if bus();

    mem_sequencer #(
        .READ_LATENCY(READ_LAT),
        .ALU_TIMEOUT (ALU_TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [7:0] ram [256];
    logic [7:0] addrPipe [4];
    logic [7:0] refMem [256];
    logic [7:0] lastResult;
    logic       lastErr;
    int         checks   = 0;
    int         failures = 0;

    function automatic logic [7:0] seedByte(input int i);
        return 8'((i * 37 + 11) & 255);
    endfunction

    // RAM contents: seeded once, then updated by the sequencer's writes.
    initial begin
        for (int i = 0; i < 256; i++) ram[i] <= seedByte(i);
        forever begin
            @(posedge clk);
            if (bus.mem_we === 1'b1) ram[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    // Read path returns the word addressed READ_LAT cycles earlier.
    always @(posedge clk) begin
        addrPipe[0] <= bus.mem_addr;
        for (int i = 1; i < 4; i++) addrPipe[i] <= addrPipe[i-1];
    end

    assign bus.mem_rdata = ram[addrPipe[READ_LAT-1]];

    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_busy"}, 16'(bus.busy), 16'd0);
        checkOutput({tag, "_done"}, 16'(bus.done), 16'd0);
        checkOutput({tag, "_we"}, 16'(bus.mem_we), 16'd0);
        checkOutput({tag, "_alustart"}, 16'(bus.alu_start), 16'd0);
        checkOutput({tag, "_error"}, 16'(bus.error), 16'(lastErr));
        checkOutput({tag, "_result"}, 16'(bus.result), 16'(lastResult));
    endtask

    // Issue one command from an idle cycle and check every cycle up to and
    // including the following idle cycle. aluAt is the cycle offset of the
    // alu_done pulse (0 = none); junkAt injects an extra start while busy.
    task automatic applyStimulus(input logic [3:0] op, input logic [7:0] a, input logic [15:0] d,
                                 input int aluAt, input int junkAt, input bit junkInDone);
        int         lat;
        bit         isAlu;
        bit         aluInWindow;
        logic       err;
        logic [7:0] expRes;
        logic       expWe;
        logic [7:0] expAddr;
        logic [7:0] expData;

        isAlu       = (op >= 4'h8);
        aluInWindow = (aluAt >= 1) && (aluAt <= ALU_TO);
        if (op == 4'h1)      lat = 2;
        else if (op == 4'h2) lat = READ_LAT + 2;
        else if (op == 4'h3) lat = 17;
        else if (isAlu)      lat = aluInWindow ? aluAt + 1 : ALU_TO + 1;
        else                 lat = 1;
        if (isAlu) err = !aluInWindow;
        else       err = !(op == 4'h1 || op == 4'h2 || op == 4'h3);
        expRes = (op == 4'h2) ? refMem[a] : lastResult;

        bus.start    = 1'b1;
        bus.opcode   = op;
        bus.adrs     = a;
        bus.data     = d;
        bus.alu_done = 1'($urandom_range(0, 1));

        for (int k = 1; k <= lat; k++) begin
            tick();
            expWe   = 1'b0;
            expAddr = '0;
            expData = '0;
            if (op == 4'h1 && k == 1) {expWe, expAddr, expData} = {1'b1, a, d[7:0]};
            if (op == 4'h3 && k <= 16) {expWe, expAddr, expData} = {1'b1, 2'b00, a[5:4], 4'(k - 1), 8'h00};
            checkOutput("busy", 16'(bus.busy), 16'(k < lat));
            checkOutput("done", 16'(bus.done), 16'(k == lat));
            checkOutput("mem_we", 16'(bus.mem_we), 16'(expWe));
            if (expWe) begin
                checkOutput("mem_addr", 16'(bus.mem_addr), 16'(expAddr));
                checkOutput("mem_wdata", 16'(bus.mem_wdata), 16'(expData));
            end
            if (op == 4'h2 && k < lat) checkOutput("rd_addr", 16'(bus.mem_addr), 16'(a));
            checkOutput("alu_start", 16'(bus.alu_start), 16'(isAlu && k == 1));
            if (isAlu && k < lat) checkOutput("alu_op", 16'(bus.alu_op), 16'(op));
            if (k == lat) begin
                checkOutput("error", 16'(bus.error), 16'(err));
                checkOutput("result", 16'(bus.result), 16'(expRes));
            end
            bus.start = (k == junkAt) || (junkInDone && k == lat);
            if (bus.start) begin
                bus.opcode = 4'($urandom_range(0, 15));
                bus.adrs   = 8'($urandom);
                bus.data   = 16'($urandom);
            end
            bus.alu_done = isAlu ? (k == aluAt) : 1'($urandom_range(0, 1));
        end

        if (op == 4'h1) refMem[a] = d[7:0];
        if (op == 4'h3) for (int i = 0; i < 16; i++) refMem[{2'b00, a[5:4], 4'(i)}] = 8'h00;
        lastErr    = err;
        lastResult = expRes;

        tick();
        checkIdle("post");
        bus.start    = 1'b0;
        bus.alu_done = 1'b0;
    endtask

    // Start a CLEAR or ALU command and reset it in cycle abortK.
    task automatic applyReset(input logic [3:0] op, input logic [7:0] a, input int abortK);
        bus.start    = 1'b1;
        bus.opcode   = op;
        bus.adrs     = a;
        bus.data     = 16'($urandom);
        bus.alu_done = 1'b0;
        for (int k = 1; k <= abortK; k++) begin
            tick();
            bus.start = 1'b0;
            checkOutput("abort_busy", 16'(bus.busy), 16'd1);
            if (op == 4'h3) begin
                checkOutput("abort_we", 16'(bus.mem_we), 16'd1);
                checkOutput("abort_addr", 16'(bus.mem_addr), 16'({2'b00, a[5:4], 4'(k - 1)}));
            end else begin
                checkOutput("abort_alustart", 16'(bus.alu_start), 16'(k == 1));
            end
            if (k == abortK) rst = 1'b1;
        end
        if (op == 4'h3) for (int i = 0; i < abortK; i++) refMem[{2'b00, a[5:4], 4'(i)}] = 8'h00;
        lastErr    = 1'b0;
        lastResult = 8'h00;
        for (int k = 0; k < 20; k++) begin
            tick();
            rst = 1'b0;
            checkIdle("after_abort");
            bus.alu_done = 1'($urandom_range(0, 1));
        end
        bus.alu_done = 1'b0;
    endtask

    initial begin
        logic [3:0] op;
        int         aluAt;
        int         junkAt;

        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.opcode   = '0;
        bus.adrs     = '0;
        bus.data     = '0;
        bus.alu_done = 1'b0;
        lastErr      = 1'b0;
        lastResult   = 8'h00;
        for (int i = 0; i < 256; i++) refMem[i] = seedByte(i);

        repeat (3) tick();
        checkOutput("rst_busy", 16'(bus.busy), 16'd0);
        checkOutput("rst_done", 16'(bus.done), 16'd0);
        checkOutput("rst_error", 16'(bus.error), 16'd0);
        checkOutput("rst_result", 16'(bus.result), 16'd0);
        checkOutput("rst_addr", 16'(bus.mem_addr), 16'd0);
        checkOutput("rst_wdata", 16'(bus.mem_wdata), 16'd0);
        checkOutput("rst_we", 16'(bus.mem_we), 16'd0);
        checkOutput("rst_alustart", 16'(bus.alu_start), 16'd0);
        checkOutput("rst_aluop", 16'(bus.alu_op), 16'd0);
        rst = 1'b0;

        $display("[TB] directed commands");
        applyStimulus(4'h1, 8'h15, 16'h00A7, 0, 0, 1'b0);
        applyStimulus(4'h1, 8'h2C, 16'h335E, 0, 0, 1'b0);
        applyStimulus(4'h2, 8'h2C, 16'h0000, 0, 0, 1'b1);
        checkOutput("read_2c", 16'(bus.result), 16'h005E);
        applyStimulus(4'h3, 8'h1B, 16'hFFFF, 0, 5, 1'b1);
        applyStimulus(4'h2, 8'h13, 16'h0000, 0, 0, 1'b0);
        applyStimulus(4'hA, 8'h00, 16'h0000, 5, 0, 1'b0);
        applyStimulus(4'hC, 8'h00, 16'h0000, 0, 3, 1'b0);
        applyStimulus(4'hD, 8'h00, 16'h0000, ALU_TO, 0, 1'b0);
        applyStimulus(4'hF, 8'h00, 16'h0000, ALU_TO + 1, 0, 1'b0);
        applyStimulus(4'h5, 8'h44, 16'h1234, 0, 0, 1'b1);
        applyStimulus(4'h0, 8'h01, 16'h0001, 0, 0, 1'b0);

        $display("[TB] reset during CLEAR and ALU_WAIT");
        applyReset(4'h3, 8'h21, 8);
        applyStimulus(4'h2, 8'h26, 16'h0000, 0, 0, 1'b0);
        applyStimulus(4'h2, 8'h29, 16'h0000, 0, 0, 1'b0);
        applyReset(4'h9, 8'h00, 4);

        $display("[TB] reset and start together");
        rst        = 1'b1;
        bus.start  = 1'b1;
        bus.opcode = 4'h1;
        bus.adrs   = 8'h77;
        bus.data   = 16'h00EE;
        tick();
        rst       = 1'b0;
        bus.start = 1'b0;
        lastErr    = 1'b0;
        lastResult = 8'h00;
        checkIdle("rst_start_a");
        tick();
        checkIdle("rst_start_b");

        $display("[TB] randomized commands");
        for (int n = 0; n < 80; n++) begin
            op     = 4'($urandom_range(0, 15));
            aluAt  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, ALU_TO + 1);
            junkAt = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 2) : 0;
            applyStimulus(op, 8'($urandom), 16'($urandom), aluAt, junkAt, 1'($urandom_range(0, 1)));
            if (n % 20 == 10)
                applyReset(($urandom_range(0, 1) == 1) ? 4'h3 : 4'hB, 8'($urandom), $urandom_range(1, ALU_TO));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
